// File: rtl/digit_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl_if
//  Description : Bus interface between the scan controller and its
//                environment. The environment side drives the enable, the
//                load strobe and the new digit nibbles. The controller side
//                drives the mux data inputs, the mux select, the active-low
//                anodes and the frame pulse.
//  Signals     : en      scan enable (0 = display blank)
//                load    one-cycle strobe capturing D0/D1
//                D0, D1  new digit values (4 bits each)
//                I0, I1  digit values presented to the 2:1 mux
//                B       mux select (0 = I0, 1 = I1)
//                an      anode enables, active-low, an[0] = digit 0
//                frame   one-cycle pulse at the start of each frame
//  Revision    : 1.0  initial release
// ============================================================================
interface digit_scan_ctrl_if;
  logic       en;
  logic       load;
  logic [3:0] D0;
  logic [3:0] D1;
  logic [3:0] I0;
  logic [3:0] I1;
  logic       B;
  logic [1:0] an;
  logic       frame;

  modport master (
    output en, load, D0, D1,
    input  I0, I1, B, an, frame
  );

  modport slave (
    input  en, load, D0, D1,
    output I0, I1, B, an, frame
  );
endinterface
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_ctrl
//  Description : Two-digit seven-segment scan controller. It cycles
//                BLANK0 -> SHOW0 -> BLANK1 -> SHOW1, driving the active-low
//                anodes and the digit mux select. A blanking interval sits
//                before each lit digit to prevent ghosting. New digit values
//                are staged in shadow registers and only reach the mux
//                inputs at a frame boundary, so no frame mixes old and new
//                digits.
//  Ports       : clk   system clock
//                rst   synchronous active-high reset
//                bus   digit_scan_ctrl_if.slave (en, load, D0, D1 in;
//                      I0, I1, B, an, frame out)
//  Parameters  : CW    slot counter width
//                DIV   cycles each digit is lit
//                DEAD  blanking cycles before each digit
//  Revision    : 1.0  initial release
// ============================================================================
module digit_scan_ctrl #(
  parameter int CW   = 20,
  parameter int DIV  = 100000,
  parameter int DEAD = 1000
) (
  input  wire                logic clk,
  input  wire                logic rst,
  digit_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  // Terminal counts, taken in CW-bit unsigned arithmetic.
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [3:0]    i0_q,    i0_d;
  logic [3:0]    i1_q,    i1_d;
  logic [3:0]    s0_q,    s0_d;
  logic [3:0]    s1_q,    s1_d;
  logic          pend_q,  pend_d;
  logic          frame_q, frame_d;

  logic [CW-1:0] slot_last;
  logic          slot_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK0;
      cnt_q   <= '0;
      i0_q    <= 4'h0;
      i1_q    <= 4'h0;
      s0_q    <= 4'h0;
      s1_q    <= 4'h0;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
    end
  end

  // Lit slots last DIV cycles, blanking slots DEAD cycles.
  always_comb begin
    slot_last = DEAD_LAST;
    if (state_q == SHOW0 || state_q == SHOW1) begin
      slot_last = DIV_LAST;
    end
  end

  assign slot_done = (cnt_q == slot_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    pend_d  = pend_q;
    frame_d = 1'b0;

    if (!bus.en) begin
      // Display is dark, so a load can go straight to the mux inputs;
      // nothing is left pending.
      state_d = BLANK0;
      cnt_d   = '0;
      if (bus.load) begin
        i0_d   = bus.D0;
        i1_d   = bus.D1;
        s0_d   = bus.D0;
        s1_d   = bus.D1;
        pend_d = 1'b0;
      end
    end else begin
      if (bus.load) begin
        s0_d   = bus.D0;
        s1_d   = bus.D1;
        pend_d = 1'b1;
      end

      if (slot_done) begin
        cnt_d = '0;
        unique case (state_q)
          BLANK0:  state_d = SHOW0;
          SHOW0:   state_d = BLANK1;
          BLANK1:  state_d = SHOW1;
          default: state_d = BLANK0;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      // Frame boundary: commit staged digits. A load in this very cycle
      // bypasses the shadow registers so it is not delayed a whole frame.
      if (state_q == SHOW1 && slot_done) begin
        frame_d = 1'b1;
        pend_d  = 1'b0;
        if (bus.load) begin
          i0_d = bus.D0;
          i1_d = bus.D1;
        end else if (pend_q) begin
          i0_d = s0_q;
          i1_d = s1_q;
        end
      end
    end
  end

  // Moore decode: select only moves while both anodes are off.
  always_comb begin
    bus.an = 2'b11;
    bus.B  = 1'b0;
    unique case (state_q)
      SHOW0: begin
        bus.an = 2'b10;
      end
      BLANK1: begin
        bus.B = 1'b1;
      end
      SHOW1: begin
        bus.an = 2'b01;
        bus.B  = 1'b1;
      end
      default: begin
        bus.an = 2'b11;
      end
    endcase
  end

  assign bus.I0    = i0_q;
  assign bus.I1    = i1_q;
  assign bus.frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan_ctrl
//  Description : Self-checking bench for digit_scan_ctrl (DIV=4, DEAD=2,
//                12-cycle frame). A reference model tracks the position
//                inside the frame as a plain integer and derives the anode
//                and select pattern arithmetically; digit staging is kept
//                as simple variables. Directed scenarios come first, then
//                a randomized run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_digit_scan_ctrl;

  localparam int CW    = 20;
  localparam int DIV   = 4;
  localparam int DEAD  = 2;
  localparam int FRAME = 2 * (DEAD + DIV);

  logic clk = 1'b0;
  logic rst = 1'b1;

  digit_scan_ctrl_if bus();

  digit_scan_ctrl #(
    .CW   (CW),
    .DIV  (DIV),
    .DEAD (DEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_pos   = 0;
  logic [3:0] m_i0    = 4'h0;
  logic [3:0] m_i1    = 4'h0;
  logic [3:0] m_s0    = 4'h0;
  logic [3:0] m_s1    = 4'h0;
  logic       m_pend  = 1'b0;
  logic       m_frame = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic l,
                            input logic [3:0] d0, input logic [3:0] d1);
    if (r) begin
      m_pos = 0; m_i0 = 0; m_i1 = 0; m_s0 = 0; m_s1 = 0;
      m_pend = 0; m_frame = 0;
    end else if (!e) begin
      m_pos = 0;
      m_frame = 0;
      if (l) begin
        m_i0 = d0; m_i1 = d1; m_s0 = d0; m_s1 = d1; m_pend = 0;
      end
    end else begin
      m_frame = (m_pos == FRAME - 1);
      if (l) begin
        m_s0 = d0; m_s1 = d1;
      end
      if (m_pos == FRAME - 1) begin
        if (l) begin
          m_i0 = d0; m_i1 = d1;
        end else if (m_pend) begin
          m_i0 = m_s0; m_i1 = m_s1;
        end
        m_pend = 0;
      end else if (l) begin
        m_pend = 1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_an;
    logic       exp_b;
    if (m_pos < DEAD)                exp_an = 2'b11;
    else if (m_pos < DEAD + DIV)     exp_an = 2'b10;
    else if (m_pos < 2 * DEAD + DIV) exp_an = 2'b11;
    else                             exp_an = 2'b01;
    exp_b = (m_pos >= DEAD + DIV);
    chk("an",    {6'd0, bus.an},    {6'd0, exp_an});
    chk("B",     {7'd0, bus.B},     {7'd0, exp_b});
    chk("I0",    {4'd0, bus.I0},    {4'd0, m_i0});
    chk("I1",    {4'd0, bus.I1},    {4'd0, m_i1});
    chk("frame", {7'd0, bus.frame}, {7'd0, m_frame});
  endtask

  // Drive inputs for the current cycle, take one edge, then check.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [3:0] d0, input logic [3:0] d1);
    rst      = r;
    bus.en   = e;
    bus.load = l;
    bus.D0   = d0;
    bus.D1   = d1;
    @(posedge clk);
    #1;
    model_edge(r, e, l, d0, d1);
    check_outputs();
  endtask

  task automatic advance_to(input int p);
    for (int k = 0; k < FRAME && m_pos != p; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    end
  endtask

  initial begin
    bus.en   = 1'b1;
    bus.load = 1'b1;
    bus.D0   = 4'h5;
    bus.D1   = 4'h0;

    // Reset with en and load active: everything stays cleared.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b1, 4'h5, 4'h0);
      chk("rst_I0", {4'd0, bus.I0}, 8'h00);
      chk("rst_an", {6'd0, bus.an}, 8'h03);
    end

    // Scan sequence: two frames; first SHOW0 at cycle 2.
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("first_show0_an", {6'd0, bus.an}, 8'h02);
    for (int k = 2; k < 2 * FRAME; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    end
    chk("frame_at_24", {7'd0, bus.frame}, 8'h01);

    // Deferred load during SHOW0 (cycle 3).
    advance_to(3);
    step(1'b0, 1'b1, 1'b1, 4'h3, 4'h9);
    chk("defer_hold_I0", {4'd0, bus.I0}, 8'h00);
    advance_to(0);
    chk("defer_I0", {4'd0, bus.I0}, 8'h03);
    chk("defer_I1", {4'd0, bus.I1}, 8'h09);

    // Load in cycle 5, then again in the SHOW1 exit cycle: last wins.
    advance_to(5);
    step(1'b0, 1'b1, 1'b1, 4'h7, 4'h2);
    advance_to(11);
    step(1'b0, 1'b1, 1'b1, 4'hA, 4'hC);
    chk("bnd_I0", {4'd0, bus.I0}, 8'h0A);
    chk("bnd_I1", {4'd0, bus.I1}, 8'h0C);
    for (int k = 0; k < FRAME; k++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    end
    chk("bnd_keep_I0", {4'd0, bus.I0}, 8'h0A);
    chk("bnd_keep_I1", {4'd0, bus.I1}, 8'h0C);

    // Enable drop in SHOW1.
    advance_to(8);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("endrop_an", {6'd0, bus.an}, 8'h03);
    chk("endrop_B",  {7'd0, bus.B},  8'h00);
    step(1'b0, 1'b0, 1'b1, 4'h1, 4'h4);
    chk("en0_load_I0", {4'd0, bus.I0}, 8'h01);
    chk("en0_load_I1", {4'd0, bus.I1}, 8'h04);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      chk("en0_frame", {7'd0, bus.frame}, 8'h00);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("reen_blank", {6'd0, bus.an}, 8'h03);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("reen_show0", {6'd0, bus.an}, 8'h02);

    // Pending load discarded by a mid-frame reset.
    advance_to(0);
    advance_to(3);
    step(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
    advance_to(7);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("midrst_an", {6'd0, bus.an}, 8'h03);
    advance_to(11);
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("midrst_I0", {4'd0, bus.I0}, 8'h00);
    chk("midrst_I1", {4'd0, bus.I1}, 8'h00);

    // Randomized run against the model.
    for (int k = 0; k < 600; k++) begin
      logic       r, e, l;
      logic [3:0] d0, d1;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      l  = ($urandom_range(0, 4) == 0);
      d0 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15));
      step(r, e, l, d0, d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Two-digit scan controller that sits directly upstream of the 4-bit 2:1 digit mux on the seven-segment display path. It holds the two digit nibbles the mux chooses between and drives the mux select. It also drives the active-low anode enables, time-multiplexing digit 0 and digit 1 with a blanking interval between them to prevent ghosting. New digit values are loaded through a shadow register and applied only at a frame boundary, so a displayed frame never mixes old and new digits.

## Interface

Parameters:
- CW, 20: width of the slot counter.
- DIV, 100000: cycles each digit is lit (1 ms at 100 MHz). Range 1 ≤ DIV ≤ 2^CW.
- DEAD, 1000: blanking cycles before each digit. Range 1 ≤ DEAD ≤ 2^CW.

Ports:
- clk  in  1  system clock. One clock domain only.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  scan enable. 0 holds the display blank.
- load  in  1  single-cycle strobe that captures D0/D1.
- D0  in  4  new digit-0 value.
- D1  in  4  new digit-1 value.
- I0  out  4  digit-0 value presented to the mux I0 input.
- I1  out  4  digit-1 value presented to the mux I1 input.
- B  out  1  mux select. 0 selects I0, 1 selects I1.
- an  out  2  anode enables, active-low. an[0] is digit 0, an[1] is digit 1.
- frame  out  1  one-cycle pulse marking the start of each new frame.

## Operation

**FSM states**, in order BLANK0 → SHOW0 → BLANK1 → SHOW1 → BLANK0:
- BLANK0: lasts DEAD cycles. an=11, B=0.
- SHOW0: lasts DIV cycles. an=10, B=0.
- BLANK1: lasts DEAD cycles. an=11, B=1.
- SHOW1: lasts DIV cycles. an=01, B=1.

**Outputs and counter**
- an and B are Moore decodes of the state register. They change on the same edge as the state.
- cnt (CW bits) clears on every state entry and increments each cycle while en=1.
- A state exits when cnt equals its duration minus 1.
- cnt never wraps. It is compared against DIV-1 or DEAD-1 in CW-bit unsigned arithmetic.

**Loading while scanning (en=1)**
- load=1 captures D0/D1 into shadow registers S0/S1 and sets pend=1.
- A later load before the frame boundary overwrites S0/S1; the last load wins.
- At the SHOW1→BLANK0 edge, if pend=1 or load=1 in that same cycle:
  - I0/I1 take the new values. If load=1 that cycle, they come from D0/D1 directly; otherwise from S0/S1.
  - pend clears.
- Otherwise I0/I1 hold.

**Enable low (en=0)**
- The next edge forces state BLANK0 and cnt=0. Outputs an=11, B=0.
- While en=0, load writes D0/D1 straight into I0/I1 (and S0/S1) and clears pend, because nothing is displayed.
- When en returns to 1, scanning restarts at BLANK0 with cnt=0.

**frame pulse**
- frame is registered. It is 1 for exactly one cycle, on the cycle after each SHOW1→BLANK0 edge.
- frame is never asserted while en=0.

**Reset**
- rst=1 at an edge sets state=BLANK0, cnt=0, I0=I1=0, S0=S1=0, pend=0, frame=0.
- Resulting outputs: B=0, an=11.
- Reset mid-frame discards any pending load.
- rst has priority over en and load.

## Timing

- Frame period with en=1 is 2·(DEAD+DIV) cycles. Cycle numbering below counts edges after rst deasserts with en=1.
- BLANK0 occupies cycles 0..DEAD-1.
- SHOW0 occupies cycles DEAD..DEAD+DIV-1.
- BLANK1 and SHOW1 follow in the same pattern.
- The load-to-display latency is variable: data appears at the next frame boundary, at most one frame period after load.
- With en=0, load updates I0/I1 on the next edge (1-cycle latency).
- An anode is never low in the same cycle that B changes. B changes only on entry to BLANK0 or BLANK1, when an=11.
- At most one anode is low in any cycle.

## Test plan

All scenarios use DIV=4, DEAD=2, giving a 12-cycle frame.

- **Reset values.** Assert rst for 3 cycles with en=1, load=1, D0=5 → I0=I1=0, B=0, an=11, frame=0 throughout. The first SHOW0 (an=10) is at cycle 2 after release.
- **Scan sequence.** en=1 for 24 cycles → per frame an = 11,11,10,10,10,10,11,11,01,01,01,01. B=1 exactly on cycles 6–11 of each frame. frame pulses at cycles 12 and 24.
- **Deferred load.** In cycle 3 (SHOW0), load D0=3, D1=9 → I0/I1 hold 0/0 through cycle 11. At cycle 12, I0=3 and I1=9.
- **Load at the boundary.** Load D0=7, D1=2 in cycle 5, then load D0=A, D1=C in the SHOW1-exit cycle 11 → at cycle 12, I0=A and I1=C, and pend=0.
- **Enable drop.** Drop en at cycle 8 (SHOW1) → an=11 and B=0 from cycle 9. A load of D0=1, D1=4 during en=0 gives I0=1 and I1=4 one edge later. When en is raised, BLANK0 lasts 2 cycles before SHOW0. No frame pulse occurs during en=0.
- **Reset mid-frame.** Load D0=F, then assert rst at cycle 7 → I0 remains 0 after the next frame boundary, and the sequence restarts at BLANK0.
